// File: rtl/booth_mac_acc_if.sv
// Handshake bundle between the Booth multiplier, the frame accumulator and
// its result consumer.
interface booth_mac_acc_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      m;
    logic             ov;
    logic [7:0]       len;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             sat;
    logic             ov_seen;

    modport master (
        output in_valid, m, ov, len, clr, out_ready,
        input  in_ready, out_valid, acc_out, sat, ov_seen
    );

    modport slave (
        input  in_valid, m, ov, len, clr, out_ready,
        output in_ready, out_valid, acc_out, sat, ov_seen
    );
endinterface

// File: rtl/booth_mac_acc.sv
// Saturating frame accumulator for 11-bit Booth products: sums len+1 products,
// then holds the clamped sum and sticky flags until the consumer takes it.
module booth_mac_acc #(
    parameter int ACC_W = 16
) (
    input logic            clk,
    input logic            rst,
    booth_mac_acc_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       rem;
    logic             accept;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sum_clamped;
    logic             clamped;

    assign bus.in_ready = (state != HOLD);
    assign accept       = bus.in_valid && bus.in_ready;

    // One guard bit: overflow shows as the top two sum bits disagreeing.
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        sum         = {bus.acc_out[ACC_W-1], bus.acc_out} + {{(ACC_W-10){bus.m[10]}}, bus.m};
        clamped     = (sum[ACC_W] != sum[ACC_W-1]);
        sum_clamped = sum[ACC_W-1:0];
        if (clamped) begin
            sum_clamped = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rem           <= '0;
            bus.acc_out   <= '0;
            bus.sat       <= 1'b0;
            bus.ov_seen   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.clr) begin
            state         <= IDLE;
            rem           <= '0;
            bus.acc_out   <= '0;
            bus.sat       <= 1'b0;
            bus.ov_seen   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.acc_out <= {{(ACC_W-11){bus.m[10]}}, bus.m};
                        rem         <= bus.len;
                        bus.sat     <= 1'b0;
                        bus.ov_seen <= bus.ov;
                        if (bus.len == 8'd0) begin
                            state         <= HOLD;
                            bus.out_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        bus.acc_out <= sum_clamped;
                        rem         <= rem - 8'd1;
                        if (clamped) bus.sat     <= 1'b1;
                        if (bus.ov)  bus.ov_seen <= 1'b1;
                        if (rem == 8'd1) begin
                            state         <= HOLD;
                            bus.out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: hand-computed frame sums, saturation,
// backpressure, abort, bubbles and reset behaviour.
module tb_booth_mac_acc;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    booth_mac_acc_if #(.ACC_W(16)) bus ();

    booth_mac_acc #(.ACC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [10:0] mv, input logic ovv, input logic [7:0] lv);
        bus.in_valid = 1'b1;
        bus.m        = mv;
        bus.ov       = ovv;
        bus.len      = lv;
        step();
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.m        = 'x;
        bus.ov       = 1'b0;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.m = '0; bus.ov = 1'b0; bus.len = '0;
        bus.clr = 1'b0; bus.out_ready = 1'b0;
        step(); step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_acc_out", bus.acc_out, 0);
        check("rst_sat", bus.sat, 0);
        check("rst_ov_seen", bus.ov_seen, 0);
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);

        // Single product frame: -1
        put(11'h7FF, 1'b0, 8'd0);
        idle_in();
        check("single_out_valid", bus.out_valid, 1);
        check("single_acc", bus.acc_out, 16'hFFFF);
        check("single_sat", bus.sat, 0);
        check("single_ov_seen", bus.ov_seen, 0);
        check("single_in_ready_hold", bus.in_ready, 0);
        take_result();
        check("single_released", bus.out_valid, 0);
        check("single_idle_ready", bus.in_ready, 1);

        // Mixed frame: 100 - 50 + 7 - 1024 = -967
        put(11'd100, 1'b0, 8'd3);
        put(11'h7CE, 1'b0, 8'd0);
        put(11'd7,   1'b0, 8'd0);
        check("mixed_no_early_valid", bus.out_valid, 0);
        put(11'h400, 1'b0, 8'd0);
        idle_in();
        check("mixed_out_valid", bus.out_valid, 1);
        check("mixed_acc", bus.acc_out, 16'hFC39);
        check("mixed_sat", bus.sat, 0);
        take_result();

        // Positive saturation: 40 x 1023 = 40920 > 32767
        for (int i = 0; i < 40; i++) put(11'd1023, 1'b0, (i == 0) ? 8'd39 : 8'd0);
        idle_in();
        check("satpos_valid", bus.out_valid, 1);
        check("satpos_acc", bus.acc_out, 16'h7FFF);
        check("satpos_sat", bus.sat, 1);
        take_result();
        put(11'd5, 1'b0, 8'd0);
        idle_in();
        check("after_sat_acc", bus.acc_out, 16'h0005);
        check("after_sat_sat", bus.sat, 0);
        take_result();

        // Negative saturation: 40 x -1024 = -40960 < -32768
        for (int i = 0; i < 40; i++) put(11'h400, 1'b0, (i == 0) ? 8'd39 : 8'd0);
        idle_in();
        check("satneg_acc", bus.acc_out, 16'h8000);
        check("satneg_sat", bus.sat, 1);
        take_result();

        // Clamp then recover without wrap: 1023 x 33 = 33759 -> 32767, then -1024 -> 31743
        for (int i = 0; i < 33; i++) put(11'd1023, 1'b0, (i == 0) ? 8'd33 : 8'd0);
        put(11'h400, 1'b0, 8'd0);
        idle_in();
        check("recover_acc", bus.acc_out, 16'h7BFF);
        check("recover_sat", bus.sat, 1);
        take_result();

        // Bubbles mid-frame with X on m: 5 + 6 = 11
        put(11'd5, 1'b0, 8'd1);
        idle_in();
        step(); step();
        check("bubble_no_valid", bus.out_valid, 0);
        check("bubble_acc_hold", bus.acc_out, 16'h0005);
        put(11'd6, 1'b0, 8'd0);
        idle_in();
        check("bubble_valid", bus.out_valid, 1);
        check("bubble_acc", bus.acc_out, 16'h000B);
        take_result();

        // Backpressure: 3 + 4 = 7 held while a product waits
        put(11'd3, 1'b0, 8'd1);
        put(11'd4, 1'b0, 8'd0);
        bus.m = 11'd100; bus.len = 8'd0;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_acc_stable", bus.acc_out, 16'h0007);
            check("bp_valid", bus.out_valid, 1);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_released", bus.out_valid, 0);
        check("bp_idle_ready", bus.in_ready, 1);
        step();
        idle_in();
        check("bp_next_valid", bus.out_valid, 1);
        check("bp_next_acc", bus.acc_out, 16'd100);
        take_result();

        // Abort after 2 of 4 products; the product presented with clr is dropped
        put(11'd1, 1'b0, 8'd3);
        put(11'd1, 1'b0, 8'd0);
        bus.clr = 1'b1;
        put(11'd1, 1'b0, 8'd0);
        bus.clr = 1'b0;
        idle_in();
        check("clr_no_valid", bus.out_valid, 0);
        check("clr_acc", bus.acc_out, 0);
        check("clr_in_ready", bus.in_ready, 1);
        step(); step();
        check("clr_still_no_valid", bus.out_valid, 0);

        // Overflow flag: 10 + 20 with ov on the second product
        put(11'd10, 1'b0, 8'd1);
        put(11'd20, 1'b1, 8'd0);
        idle_in();
        check("ov_valid", bus.out_valid, 1);
        check("ov_acc", bus.acc_out, 16'd30);
        check("ov_seen", bus.ov_seen, 1);
        take_result();

        // Reset while in HOLD
        put(11'd9, 1'b0, 8'd0);
        idle_in();
        check("hold_before_rst", bus.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_hold_valid", bus.out_valid, 0);
        check("rst_hold_acc", bus.acc_out, 0);
        check("rst_hold_ready", bus.in_ready, 1);

        // Reset mid-frame: no result pulse afterwards
        put(11'd1, 1'b0, 8'd2);
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); step(); step();
        check("rst_mid_no_valid", bus.out_valid, 0);
        check("rst_mid_ready", bus.in_ready, 1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/booth_mac_acc.md
BOOTH_MAC_ACC -- requirements
Module: booth_mac_acc

Interface
REQ-001 The block SHALL have parameter ACC_W, default 16, giving the signed accumulator and result width; the legal range is 12..32.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port in_valid, input, 1 bit: a product is presented on m/ov.
REQ-005 Port in_ready, output, 1 bit: the block accepts a product this cycle.
REQ-006 Port m, input, 11 bits: the two's-complement product from the upstream 6x6 radix-4 Booth multiplier.
REQ-007 Port ov, input, 1 bit: the multiplier overflow flag qualifying m.
REQ-008 Port len, input, 8 bits: products per frame minus 1 (1..256); sampled only on the first accept of a frame.
REQ-009 Port clr, input, 1 bit: synchronous frame abort.
REQ-010 Port out_valid, output, 1 bit: the frame result is available.
REQ-011 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 Port acc_out, output, ACC_W bits: the signed, saturated frame sum.
REQ-013 Port sat, output, 1 bit: sticky flag, set if any clamp occurred in the frame.
REQ-014 Port ov_seen, output, 1 bit: sticky flag, set if any accepted product had ov=1.

Function
REQ-015 The block SHALL have three states: IDLE, ACC and HOLD.
REQ-016 An accept SHALL be in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-017 On an accept in IDLE, the block SHALL:
- load acc = sign-extended m;
- load rem = len;
- clear then set sat and ov_seen from the first product;
- go to ACC if len != 0, or to HOLD if len == 0.
REQ-018 On an accept in ACC, the block SHALL:
- form sum = acc + sext(m) at ACC_W+1 bits;
- clamp the sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1];
- set sat if the sum was clamped;
- set ov_seen if ov=1;
- decrement rem, and go to HOLD when rem was 1.
REQ-019 After a clamp, accumulation SHALL continue from the clamped value, with no wrap-around.
REQ-020 Cycles without an accept in ACC SHALL leave all state unchanged (bubbles allowed).
REQ-021 In HOLD:
- out_valid SHALL be 1;
- acc_out, sat and ov_seen SHALL be held stable until out_ready=1;
- on out_ready=1 the block SHALL go to IDLE, with out_valid=0 on the next cycle.
REQ-022 Latency: out_valid SHALL rise the cycle after the final product's accept; throughput SHALL be one product per cycle.
REQ-023 Every output SHALL be registered, except in_ready, which SHALL decode directly from state.
REQ-024 clr=1 in any state SHALL, on the next cycle:
- force IDLE;
- clear acc, rem, sat, ov_seen and out_valid;
- discard the product presented with clr.
REQ-025 Priority SHALL be rst > clr > accept/handshake.
REQ-026 Out-of-frame m/ov values SHALL have no effect; X on m while in_valid=0 SHALL NOT propagate.

Reset
REQ-027 While rst=1, at each clk edge the block SHALL set state=IDLE, acc_out=0, rem=0, sat=0, ov_seen=0 and out_valid=0.
REQ-028 Reset asserted mid-frame or in HOLD SHALL drop the frame with no out_valid pulse.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 Single product: len=0, m=11'h7FF (-1) -> one cycle later out_valid=1, acc_out=16'hFFFF, sat=0, ov_seen=0.
REQ-031 Mixed frame: len=3, m=100, -50, 7, 11'h400 (-1024) back-to-back -> acc_out=16'hFC39 (-967), out_valid on the cycle after the 4th accept.
REQ-032 Saturation: len=39, 40 products of 1023 -> acc_out=16'h7FFF and sat=1; then len=0, m=5 -> sat=0 and acc_out=5.
REQ-033 Backpressure: frame complete with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0, acc_out stable, no product consumed; out_ready=1 -> IDLE, and the next product is accepted.
REQ-034 Abort and overflow:
- clr after 2 of 4 products -> no out_valid;
- following frame len=1, m=10, 20 with ov=1 on the second -> acc_out=30, ov_seen=1.
REQ-035 Reset: rst pulse while in HOLD -> out_valid=0 and acc_out=0 next cycle, in_ready=1.
